// File: rtl/pipeline_control_if.sv
// Signal bundle between the hazard detector / fetch side and pipeline_control.
interface pipeline_control_if;
    logic       fetch_valid;
    logic       hazard_detected;
    logic [3:0] stall_activate;
    logic       flush_req;
    logic       mem_busy;
    logic       en_if;
    logic       en_id;
    logic       en_ex;
    logic       en_mem;
    logic       en_wb;
    logic       valid_1;
    logic       valid_2;
    logic       valid_3;
    logic       pc_redirect;

    modport master (
        output fetch_valid, hazard_detected, stall_activate, flush_req, mem_busy,
        input  en_if, en_id, en_ex, en_mem, en_wb, valid_1, valid_2, valid_3, pc_redirect
    );

    modport slave (
        input  fetch_valid, hazard_detected, stall_activate, flush_req, mem_busy,
        output en_if, en_id, en_ex, en_mem, en_wb, valid_1, valid_2, valid_3, pc_redirect
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline sequencer: per-stage enables, valid tracking, load-use stalls, flushes, memory freezes.
// Optional perf counters (stall_count, flush_count) enabled by defining PIPE_PERF_CNT_EN.
module pipeline_control #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipeline_control_if.slave  pipe
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
`endif
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [CNT_W-1:0] STALL_RELOAD =
        CNT_W'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             v_ifid_q, v_idex_q, v_exmem_q, v_memwb_q;
    logic             v_ifid_d, v_idex_d, v_exmem_d, v_memwb_d;
    logic             load_use, flush, bubble, flush_take, redirect;

    assign load_use = pipe.hazard_detected && (pipe.stall_activate[3:2] == 2'b11);
    assign flush    = pipe.flush_req | pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        v_ifid_d   = v_ifid_q;
        v_idex_d   = v_idex_q;
        v_exmem_d  = v_exmem_q;
        v_memwb_d  = v_memwb_q;
        bubble     = 1'b0;
        flush_take = 1'b0;
        redirect   = 1'b0;
        if (!pipe.mem_busy) begin
            v_exmem_d = v_idex_q;
            v_memwb_d = v_exmem_q;
            case (state_q)
                FLUSH: begin
                    redirect = 1'b1;
                    v_ifid_d = 1'b0;
                    v_idex_d = v_ifid_q;
                    state_d  = RUN;
                end
                default: begin
                    if (flush) begin
                        flush_take = 1'b1;
                        v_ifid_d   = 1'b0;
                        v_idex_d   = 1'b0;
                        state_d    = FLUSH;
                    end else if (state_q == STALL || load_use) begin
                        // IF/ID holds its instruction while a bubble enters ID/EX
                        bubble   = 1'b1;
                        v_idex_d = 1'b0;
                        if (state_q == STALL) begin
                            if (cnt_q == '0) state_d = RUN;
                            else             cnt_d   = cnt_q - 1'b1;
                        end else if (STALL_CYCLES > 1) begin
                            cnt_d   = STALL_RELOAD;
                            state_d = STALL;
                        end
                    end else begin
                        v_ifid_d = pipe.fetch_valid;
                        v_idex_d = v_ifid_q;
                    end
                end
            endcase
        end
        // A flush seen during a freeze is remembered until it can be applied
        pend_d = pipe.mem_busy ? (pend_q | pipe.flush_req) : (pend_q & ~flush_take);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            v_ifid_q  <= 1'b0;
            v_idex_q  <= 1'b0;
            v_exmem_q <= 1'b0;
            v_memwb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            v_ifid_q  <= v_ifid_d;
            v_idex_q  <= v_idex_d;
            v_exmem_q <= v_exmem_d;
            v_memwb_q <= v_memwb_d;
        end
    end

    assign pipe.en_if       = rst_n & ~pipe.mem_busy & ~bubble;
    assign pipe.en_id       = rst_n & ~pipe.mem_busy & ~bubble;
    assign pipe.en_ex       = rst_n & ~pipe.mem_busy;
    assign pipe.en_mem      = rst_n & ~pipe.mem_busy;
    assign pipe.en_wb       = rst_n & ~pipe.mem_busy & v_memwb_q;
    assign pipe.pc_redirect = rst_n & redirect;
    assign pipe.valid_1     = v_idex_q;
    assign pipe.valid_2     = v_exmem_q;
    assign pipe.valid_3     = v_memwb_q;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (bubble && stall_count != '1)     stall_count <= stall_count + 1'b1;
            if (flush_take && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: one instance with 1 stall bubble, one with 3.
module tb_pipeline_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fv, hz, fl, mb;
    logic [3:0] sa;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_control_if b1 ();
    pipeline_control_if b3 ();

    assign b1.fetch_valid     = fv;
    assign b1.hazard_detected = hz;
    assign b1.stall_activate  = sa;
    assign b1.flush_req       = fl;
    assign b1.mem_busy        = mb;
    assign b3.fetch_valid     = fv;
    assign b3.hazard_detected = hz;
    assign b3.stall_activate  = sa;
    assign b3.flush_req       = fl;
    assign b3.mem_busy        = mb;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] sc1, fc1;
    logic [3:0]  sc3, fc3;
`endif

    pipeline_control #(.STALL_CYCLES(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe        (b1)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_count (sc1),
        .flush_count (fc1)
`endif
    );

    pipeline_control #(.STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe        (b3)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_count (sc3),
        .flush_count (fc3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fv = 1'b1; hz = 1'b0; sa = 4'b0000; fl = 1'b0; mb = 1'b0;
        tick(); tick(); #1;
        check("rst_en3",    {b3.en_if, b3.en_id, b3.en_ex, b3.en_mem, b3.en_wb, b3.pc_redirect}, 0);
        check("rst_valid1", {b1.valid_1, b1.valid_2, b1.valid_3}, 0);
        rst_n = 1'b1; #1;
        check("rel_en_if", b1.en_if, 1);
        tick(); tick(); tick(); tick();
        check("fill_valid", {b1.valid_1, b1.valid_2, b1.valid_3}, 3'b111);
        check("fill_en_wb", b1.en_wb, 1);

        // load-use pulse seen by both instances
        hz = 1'b1; sa = 4'b1100; #1;
        check("lu1_front", {b1.en_if, b1.en_id}, 2'b00);
        check("lu1_back",  {b1.en_ex, b1.en_mem, b1.en_wb}, 3'b111);
        check("lu3_en_if_c0", b3.en_if, 0);
        tick(); hz = 1'b0; sa = 4'b0000; #1;
        check("lu1_no_stall", b1.en_if, 1);
        check("lu1_v1_bubble", b1.valid_1, 0);
        check("lu3_en_if_c1", b3.en_if, 0);
        check("lu3_v1_b1", b3.valid_1, 0);
        tick(); #1;
        check("lu1_v2_bubble", b1.valid_2, 0);
        check("lu1_v1_back", b1.valid_1, 1);
        check("lu3_en_if_c2", b3.en_if, 0);
        check("lu3_v1_b2", b3.valid_1, 0);
        tick(); #1;
        check("lu3_en_if_c3", b3.en_if, 1);
        check("lu3_v1_b3", b3.valid_1, 0);
        tick(); #1;
        check("lu3_v1_back", b3.valid_1, 1);

        // hazard without stall_activate is bypass only
        hz = 1'b1; sa = 4'b0000; #1;
        check("byp_en_if1", b1.en_if, 1);
        check("byp_en_if3", b3.en_if, 1);
        tick(); hz = 1'b0; #1;
        check("byp_v1", b3.valid_1, 1);

        // flush while b3 is stalling
        hz = 1'b1; sa = 4'b1100;
        tick(); hz = 1'b0; sa = 4'b0000; fl = 1'b1; #1;
        check("fs_en_if", b3.en_if, 1);
        check("fs_pc_pre", b3.pc_redirect, 0);
        tick(); fl = 1'b0; #1;
        check("fs_pc3", b3.pc_redirect, 1);
        check("fs_pc1", b1.pc_redirect, 1);
        check("fs_v1_a", b3.valid_1, 0);
        tick(); #1;
        check("fs_pc_off", b3.pc_redirect, 0);
        check("fs_v1_b", b3.valid_1, 0);
        tick(); #1;
        check("fs_v1_c", b3.valid_1, 0);
        tick(); #1;
        check("fs_v1_d", b3.valid_1, 1);
        tick(); tick(); tick();
        check("refill", {b1.valid_1, b1.valid_2, b1.valid_3}, 3'b111);

        // freeze with a flush arriving mid-freeze
        mb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fl = (i == 1);
            #1;
            check("frz_en", {b1.en_if, b1.en_id, b1.en_ex, b1.en_mem, b1.en_wb, b1.pc_redirect}, 0);
            tick();
        end
        check("frz_hold", {b1.valid_1, b1.valid_3}, 2'b11);
        mb = 1'b0; fl = 1'b0; #1;
        check("frz_release_en", b1.en_if, 1);
        check("frz_release_pc", b1.pc_redirect, 0);
        tick(); #1;
        check("frz_flush_pc1", b1.pc_redirect, 1);
        check("frz_flush_pc3", b3.pc_redirect, 1);
        check("frz_flush_v1", b1.valid_1, 0);
        tick(); #1;
        check("frz_pc_off", b1.pc_redirect, 0);
        tick(); tick(); tick(); tick();

`ifdef PIPE_PERF_CNT_EN
        check("perf_sc3_a", sc3, 4);
        check("perf_fc3",   fc3, 2);
        check("perf_sc1_a", sc1, 2);
        check("perf_fc1",   fc1, 2);
        hz = 1'b1; sa = 4'b1100;
        repeat (20) tick();
        hz = 1'b0; sa = 4'b0000;
        tick();
        check("perf_sc3_sat", sc3, 4'hF);
        check("perf_sc1_b",   sc1, 22);
        check("perf_fc3_b",   fc3, 2);
`endif
        tick(); tick(); tick();

        // asynchronous reset in the middle of a stall
        hz = 1'b1; sa = 4'b1100;
        tick(); hz = 1'b0; sa = 4'b0000; #1;
        check("rs_in_stall", b3.en_if, 0);
        rst_n = 1'b0; #1;
        check("rs_en3",    {b3.en_if, b3.en_id, b3.en_ex, b3.en_mem, b3.en_wb, b3.pc_redirect}, 0);
        check("rs_valid3", {b3.valid_1, b3.valid_2, b3.valid_3}, 0);
`ifdef PIPE_PERF_CNT_EN
        check("rs_cnt3", {sc3, fc3}, 0);
`endif
        tick(); rst_n = 1'b1; #1;
        check("rs_run_en_if", b3.en_if, 1);
        tick(); #1;
        check("rs_run_en_if2", b3.en_if, 1);
        check("rs_v1", b3.valid_1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
